// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the crossbar request/grant arbiter.
package arb_pkg;

    localparam int N_MASTER_DEF = 16;
    localparam int TIMEOUT_DEF  = 1024;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t IDLE  = 1'b0;
    localparam arb_state_t GRANT = 1'b1;

    // Next index in rotating order, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority find-first: scans eligible starting at ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int         pos;
        logic [W-1:0] pos_w;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        pos_w = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            pos_w = W'(pos);
            if (!found && eligible[pos_w]) begin
                found = 1'b1;
                idx   = pos_w;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one owner holds the crossbar until it drops its
// request or the watchdog forces release; timed-out masters stay masked until they drop.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_MASTER = N_MASTER_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int OWNER_W  = $clog2(N_MASTER)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_MASTER-1:0] request,
    output logic [N_MASTER-1:0] grant,
    output logic [OWNER_W-1:0]  owner,
    output logic                busy,
    output logic                timeout
);

    localparam int HC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [HC_W-1:0] HC_MAX  = '1;

    arb_state_t            state;
    logic [OWNER_W-1:0]    ptr;
    logic [N_MASTER-1:0]   mask;
    logic [HC_W-1:0]       hold_cnt;

    logic [N_MASTER-1:0]   eligible;
    logic                  pick_found;
    logic [OWNER_W-1:0]    pick_idx;
    logic [N_MASTER-1:0]   pick_onehot;
    logic [N_MASTER-1:0]   owner_onehot;
    logic [OWNER_W-1:0]    owner_inc;
    logic                  owner_req;
    logic                  expire;

    assign eligible = request & ~mask;

    rr_pick #(
        .N (N_MASTER),
        .W (OWNER_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        pick_onehot            = '0;
        pick_onehot[pick_idx]  = 1'b1;
        owner_onehot           = '0;
        owner_onehot[owner]    = 1'b1;
    end

    assign owner_inc = OWNER_W'(wrap_inc(int'(owner), N_MASTER));
    assign owner_req = request[owner];
    // A drop on the expiry edge is a normal release, so expiry only counts while still requested.
    assign expire    = (TIMEOUT != 0) && owner_req && (hold_cnt == HC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            mask     <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            mask    <= (mask & request) | ((state == GRANT && expire) ? owner_onehot : '0);
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_onehot;
                        owner    <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req || expire) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= expire;
                        ptr     <= owner_inc;
                        state   <= IDLE;
                    end else if (hold_cnt != HC_MAX) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus random
// request traffic, all checked every cycle against a queue/integer-level model.
module tb_bus_arbiter;

    localparam int N  = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  request;
    logic [N-1:0]  grant;
    logic [3:0]    owner;
    logic          busy;
    logic          timeout;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N_MASTER (N),
        .TIMEOUT  (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (request),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_owner = -1 means nobody holds the bus.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_held  = 0;
    bit           m_to    = 1'b0;
    logic [N-1:0] m_mask  = '0;

    always @(posedge clk) begin : model
        logic [N-1:0] elig;
        logic [N-1:0] nmask;
        int           pick;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
            m_mask  = '0;
        end else begin
            m_to  = 1'b0;
            nmask = m_mask & request;
            if (m_owner < 0) begin
                elig = request & ~m_mask;
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && elig[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                if (pick >= 0) begin
                    m_owner = pick;
                    m_held  = 1;
                end
            end else if (!request[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_held == TO) begin
                m_to           = 1'b1;
                nmask[m_owner] = 1'b1;
                m_ptr          = (m_owner + 1) % N;
                m_owner        = -1;
            end else begin
                m_held++;
            end
            m_mask = nmask;
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] eg;
        if (chk_en) begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            chk("m_grant", 32'(grant), 32'(eg));
            chk("m_busy", 32'(busy), 32'(m_owner >= 0));
            chk("m_timeout", 32'(timeout), 32'(m_to));
            if (m_owner >= 0) chk("m_owner", 32'(owner), 32'(m_owner));
        end
    end

    initial begin
        logic [N-1:0] rr_exp [4];
        int           rate;
        rr_exp[0] = 16'h8000;
        rr_exp[1] = 16'h0001;
        rr_exp[2] = 16'h8000;
        rr_exp[3] = 16'h0001;

        rst_n   = 1'b0;
        request = '0;
        chk_en  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        // single requester
        @(negedge clk); request = 16'h0004;
        @(negedge clk);
        chk("single_grant", 32'(grant), 32'h0004);
        chk("single_owner", 32'(owner), 32'd2);
        chk("single_busy", 32'(busy), 32'h1);
        repeat (3) @(negedge clk);
        request = '0;
        @(negedge clk);
        chk("single_release", 32'(grant), 32'h0);
        chk("single_release_busy", 32'(busy), 32'h0);

        // round robin between masters 0 and 15, one idle cycle between owners
        request = 16'h8001;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(rr_exp[r]));
            repeat (2) @(negedge clk);
            request = 16'h8001 & ~rr_exp[r];
            @(negedge clk);
            chk("rr_gap", 32'(grant), 32'h0);
            request = 16'h8001;
        end

        // wrap-around after master 15 releases
        @(negedge clk);
        chk("wrap_pre", 32'(grant), 32'h8000);
        request = '0;
        @(negedge clk);
        chk("wrap_gap", 32'(grant), 32'h0);
        request = 16'h8002;
        @(negedge clk);
        chk("wrap_grant", 32'(grant), 32'h0002);
        request = '0;
        @(negedge clk);

        // watchdog: 8 grant cycles, one timeout pulse, then masked
        request = 16'h0008;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            chk("wd_hold", 32'(grant), 32'h0008);
        end
        @(negedge clk);
        chk("wd_release", 32'(grant), 32'h0);
        chk("wd_pulse", 32'(timeout), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_masked", 32'(grant), 32'h0);
            chk("wd_pulse_once", 32'(timeout), 32'h0);
        end
        request = '0;
        @(negedge clk);
        request = 16'h0008;
        @(negedge clk);
        chk("wd_regrant", 32'(grant), 32'h0008);

        // drop on the expiry edge: normal release, no pulse, no mask
        repeat (TO - 1) @(negedge clk);
        chk("sim_hold", 32'(grant), 32'h0008);
        request = '0;
        @(negedge clk);
        chk("sim_release", 32'(grant), 32'h0);
        chk("sim_no_pulse", 32'(timeout), 32'h0);
        request = 16'h0008;
        @(negedge clk);
        chk("sim_not_masked", 32'(grant), 32'h0008);

        // reset in the middle of a grant
        request = '0;
        @(negedge clk);
        request = 16'h0010;
        @(negedge clk);
        chk("mid_pre", 32'(grant), 32'h0010);
        rst_n   = 1'b0;
        request = 16'h0030;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after_grant", 32'(grant), 32'h0010);
        chk("mid_after_owner", 32'(owner), 32'd4);

        // random traffic: fast churn first, then slow churn that reaches the watchdog
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rate = (c < 2000) ? 9 : 39;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, rate) == 0) request[b] = ~request[b];
            rst_n = ($urandom_range(0, 399) != 0);
        end

        rst_n   = 1'b1;
        request = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Request/grant arbiter that feeds the crossbar's `grant` vector from the masters' `request` vector.
- Sits directly upstream of the crossbar. One master owns the shared crossbar path at a time.
- Rotating-priority (round-robin) selection.
- Ownership is held until the owner drops its request, or until a watchdog timeout forces release.

Parameters:
- N_MASTER, 16, number of requesting masters (width of request/grant).
- TIMEOUT, 1024, max consecutive grant cycles before forced release; 0 disables the watchdog.
- OWNER_W, $clog2(N_MASTER), width of owner index.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- request  input  N_MASTER  per-master bus request, level-held for the whole transaction
- grant  output  N_MASTER  one-hot (or zero) registered grant to crossbar
- owner  output  OWNER_W  index of current grantee; valid only while busy=1
- busy  output  1  high while any grant bit is set
- timeout  output  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (rst_n=0 at rising edge): grant=0, owner=0, busy=0, timeout=0, ptr=0, mask=0, hold_cnt=0, state=IDLE. Takes effect on that edge even mid-grant.
- All outputs are registered; no combinational path from request to grant.
- eligible = request & ~mask.
- ptr = highest-priority index. Search order is ptr, ptr+1, …, N_MASTER-1, 0, …, ptr-1 (wraps modulo N_MASTER).
- State IDLE:
  - If eligible != 0 at edge t: at t+1 grant = onehot(pick), owner = pick, busy=1, hold_cnt=0, state=GRANT.
  - Otherwise remain IDLE with grant=0.
- State GRANT, evaluated each edge:
  - (a) request[owner]==0: next cycle grant=0, busy=0, ptr=owner+1 (wrap), state=IDLE. No timeout.
  - (b) Else if TIMEOUT!=0 and hold_cnt==TIMEOUT-1: next cycle grant=0, busy=0, timeout=1 for exactly one cycle, mask[owner]=1, ptr=owner+1, state=IDLE.
  - (c) Else hold_cnt += 1; grant unchanged.
- Precedence: (a) beats (b). A request drop in the same cycle as expiry is a normal release with no timeout pulse and no mask set.
- Grant latency: 1 cycle from eligible request sampled in IDLE.
- Minimum grant-to-grant gap: one full cycle with grant=0 between owners, including the same master re-requesting.
- Mask: mask[i] clears on any edge where request[i]==0. A timed-out master must deassert request for ≥1 cycle before it is eligible again.
- Request changes of non-owners during GRANT are ignored. Only the IDLE-state sample matters.
- hold_cnt width: $clog2(TIMEOUT+1). hold_cnt saturates rather than wraps when TIMEOUT=0.
- Invariants:
  - $onehot0(grant) always holds.
  - busy == |grant.
  - grant[owner]==busy.

Decomposition:
- Shared package `arb_pkg`: N_MASTER default constant; state enum {IDLE, GRANT}.
- Sub-module `rr_pick`: purely combinational rotating-priority find-first. Inputs: eligible vector and ptr. Outputs: found flag and index.
- Arbiter FSM, counter and mask live in bus_arbiter.

Test Plan:
- Single requester: reset, then request=16'h0004 at cycle 5 → grant=16'h0004, owner=2, busy=1 at cycle 6. Drop request at cycle 10 → grant=0 at cycle 11.
- Round-robin fairness: request=16'h8001 held continuously, each owner releasing after 3 cycles then re-raising → grants alternate 16'h0001, 16'h8000, 16'h0001…, with exactly one idle cycle between each.
- Wrap-around: after owner=15 releases, request=16'h8002 → next grant is 16'h0002 (ptr wrapped to 0, index 1 found first).
- Watchdog: TIMEOUT=8, master 3 holds request indefinitely → grant[3] high for 8 cycles, then grant=0 and timeout=1 for one cycle. A held request=16'h0008 gets no further grant. Master 3 drops for 1 cycle and re-raises → granted again.
- Simultaneous drop/expiry: TIMEOUT=8, owner drops request on the expiry edge → timeout stays 0 and the master is not masked.
- Reset mid-operation: rst_n=0 while grant=16'h0010 → grant=0, busy=0 at the next edge. After reset release with request=16'h0030, grant=16'h0010 (ptr reset to 0).
